// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the multiplexed 7-segment display
//
// Contents:
//   SEG_BLANK, SEG_E, SEG_DIGIT[0:9] : active-low {g,f,e,d,c,b,a} patterns
//   AN_OFF                           : all anodes released (active-low)
//   CODE_E, CODE_BLANK               : special digit codes understood by seg7_decoder
//   digit_idx_t                      : 2-bit scan slot index
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - digit code to active-low 7-segment pattern
//
// Ports:
//   i_code  in  4  0-9 decimal digit, 4'hE = "E", 4'hF (or any other) = blank
//   o_seg   out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
    import disp_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_code <= 4'd9) begin
            o_seg = SEG_DIGIT[i_code];
        end else if (i_code == CODE_E) begin
            o_seg = SEG_E;
        end
    end

endmodule

// File: rtl/display_mux7seg.sv
// rtl/display_mux7seg.sv - captures divider quotient/remainder and scans them onto a 4-digit display
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst     in   1  asynchronous active-low reset
//   load    in   1  capture strobe for result/resto
//   result  in   4  quotient
//   resto   in   4  remainder
//   seg     out  7  active-low segments {g,f,e,d,c,b,a}
//   an      out  4  active-low anodes, an[3] leftmost
//   dp      out  1  decimal point, always off (1)
// Optional feature macro: DISP_ERR_BLINK_EN (blinks the "E" display on a divider error)
module display_mux7seg
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] result,
    input  logic [3:0] resto,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    generate
        if (REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
            $error("display_mux7seg: REFRESH_DIV must be >= 2 and BLINK_DIV >= 1");
        end
    endgenerate

    logic [3:0]    r_q;
    logic [3:0]    r_r;
    logic          r_err;
    logic [PW-1:0] r_presc;
    digit_idx_t    r_idx;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_wrap;
    logic [3:0]    w_value;
    logic          w_tens;
    logic [3:0]    w_units;
    logic [3:0]    w_code;
    logic [6:0]    w_seg;
    logic [3:0]    w_an_sel;
    logic          w_dark;

    assign w_wrap = (r_presc == PW'(REFRESH_DIV - 1));

    // Odd slots carry units, even slots tens; upper half of the scan is the remainder.
    assign w_value = r_idx[1] ? r_r : r_q;
    assign w_tens  = (w_value >= 4'd10);
    assign w_units = w_tens ? (w_value - 4'd10) : w_value;

    always_comb begin
        w_code = w_units;
        if (r_err) begin
            w_code = CODE_E;
        end else if (!r_idx[0]) begin
            w_code = w_tens ? 4'd1 : CODE_BLANK;
        end
    end

    seg7_decoder u_dec (
        .i_code (w_code),
        .o_seg  (w_seg)
    );

    always_comb begin
        case (r_idx)
            2'd0:    w_an_sel = 4'b0111;
            2'd1:    w_an_sel = 4'b1011;
            2'd2:    w_an_sel = 4'b1101;
            default: w_an_sel = 4'b1110;
        endcase
    end

`ifdef DISP_ERR_BLINK_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (load) begin
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // First cycle of each slot stays dark so the previous digit cannot ghost.
    assign w_dark = (r_presc == '0) || (r_err && !r_blink_on);
`else
    assign w_dark = (r_presc == '0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            r_r     <= '0;
            r_err   <= 1'b0;
            r_presc <= '0;
            r_idx   <= '0;
            r_seg   <= SEG_BLANK;
            r_an    <= AN_OFF;
        end else begin
            if (load) begin
                r_q   <= result;
                r_r   <= resto;
                r_err <= (result == 4'hF) && (resto == 4'hF);
            end
            if (w_wrap) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_seg <= w_seg;
            r_an  <= w_dark ? AN_OFF : w_an_sel;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_display_mux7seg.sv
// tb/tb_display_mux7seg.sv - directed self-checking bench for display_mux7seg
module tb_display_mux7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] result;
    logic [3:0] resto;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_mux7seg #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .result (result),
        .resto  (resto),
        .seg    (seg),
        .an     (an),
        .dp     (dp)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] q, input logic [3:0] r);
        result = q;
        resto  = r;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    // Leaves the bench on the first lit cycle of slot 0 (dead cycle just seen).
    task automatic sync_slot0(input string tag);
        logic [3:0] prev;
        logic       found;
        prev  = an;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            step();
            if (prev == 4'hF && an == 4'b0111) found = 1'b1;
            prev = an;
        end
        if (!found) check({tag, "_sync_timeout"}, 8'd0, 8'd1);
    endtask

    task automatic do_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg = '{e0, e1, e2, e3};
        exp_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        sync_slot0(tag);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                step();
                check($sformatf("%s_dead%0d", tag, s), {4'd0, an}, 8'h0F);
                step();
            end
            for (int c = 0; c < 3; c++) begin
                if (c > 0) step();
                check($sformatf("%s_an%0d_%0d", tag, s, c), {4'd0, an}, {4'd0, exp_an[s]});
                check($sformatf("%s_seg%0d_%0d", tag, s, c), {1'b0, seg}, {1'b0, exp_seg[s]});
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        load   = 1'b0;
        result = 4'd0;
        resto  = 4'd0;
        step();
        step();
        check("rst_an", {4'd0, an}, 8'h0F);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_dp", {7'd0, dp}, 8'h01);

        rst = 1'b1;
        step();
        check("rel_first_an", {4'd0, an}, 8'h0F);
        step();
        check("rel_slot0_an", {4'd0, an}, 8'h07);
        check("rel_slot0_seg", {1'b0, seg}, 8'h7F);
        step();
        check("rel_slot0_seg_b", {1'b0, seg}, 8'h7F);

        // Reset mid-scan after some data was loaded.
        do_load(4'd7, 4'd3);
        step();
        step();
        step();
        rst = 1'b0;
        #2;
        check("midrst_an", {4'd0, an}, 8'h0F);
        check("midrst_seg", {1'b0, seg}, 8'h7F);
        check("midrst_dp", {7'd0, dp}, 8'h01);
        step();
        rst = 1'b1;
        step();
        check("midrst_rel_an", {4'd0, an}, 8'h0F);
        step();
        check("midrst_rel_an0", {4'd0, an}, 8'h07);
        check("midrst_rel_seg0", {1'b0, seg}, 8'h7F);

        do_load(4'd7, 4'd3);
        do_scan("q7r3", 7'h7F, 7'h78, 7'h7F, 7'h30);

        do_load(4'd12, 4'd10);
        do_scan("q12r10", 7'h79, 7'h24, 7'h79, 7'h40);

        do_load(4'd9, 4'd10);
        do_scan("q9r10", 7'h7F, 7'h10, 7'h79, 7'h40);

        do_load(4'd15, 4'd0);
        do_scan("q15r0", 7'h79, 7'h12, 7'h7F, 7'h40);

        do_load(4'd15, 4'd14);
        do_scan("q15r14", 7'h79, 7'h12, 7'h79, 7'h19);

`ifdef DISP_ERR_BLINK_EN
        begin
            int active;
            int run;
            int max_run;
            active  = 0;
            run     = 0;
            max_run = 0;
            do_load(4'hF, 4'hF);
            for (int k = 0; k < 32; k++) begin
                step();
                if (an != 4'hF) begin
                    active++;
                    run = 0;
                end else begin
                    run++;
                    if (run > max_run) max_run = run;
                end
            end
            check("blink_active_le16", {7'd0, active <= 16}, 8'h01);
            check("blink_dark_run_ge8", {7'd0, max_run >= 8}, 8'h01);
        end
`else
        do_load(4'hF, 4'hF);
        do_scan("err", 7'h06, 7'h06, 7'h06, 7'h06);
`endif

        do_load(4'd0, 4'd0);
        do_scan("q0r0", 7'h7F, 7'h40, 7'h7F, 7'h40);
        check("dp_end", {7'd0, dp}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
